// File: rtl/aes_inv_mix_col_seq_pkg.sv
// Shared widths, sequencer state encoding and GF(2^8) helpers for the
// InvMixColumns datapath.
package aes_inv_mix_col_seq_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;
    localparam int AES_NCOLS   = 4;

    typedef enum logic [1:0] {
        AES_SEQ_IDLE = 2'd0,
        AES_SEQ_RUN  = 2'd1,
        AES_SEQ_DONE = 2'd2
    } aes_seq_e;

    // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; the InvMixColumns coefficients are 9, b, d, e
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_mix_col.sv
// InvMixColumns on a single 32-bit column; byte s0 is the column MSB.
module aes_inv_mix_col
    import aes_inv_mix_col_seq_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_in;

    assign col_out[31:24] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
    assign col_out[23:16] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
    assign col_out[15:8]  = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
    assign col_out[7:0]   = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);

endmodule

// File: rtl/aes_inv_mix_col_seq.sv
// Column-serial InvMixColumns sequencer: one 128-bit state in, NCOL columns
// transformed per cycle, transformed state out over a valid/ready handshake.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a state; in_ready high once out of reset
// RUN   | NCOL columns per cycle written back; in bypass mode one cycle
//       | with write-back suppressed so the state passes through untouched
// DONE  | out_valid high, out_state held until out_ready
module aes_inv_mix_col_seq
    import aes_inv_mix_col_seq_pkg::*;
#(
    parameter int NCOL = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    generate
        if (NCOL != 1 && NCOL != 2 && NCOL != 4) begin : g_bad_ncol
            $error("aes_inv_mix_col_seq: NCOL must be 1, 2 or 4");
        end
    endgenerate

    // Counter value of the final column group; the 2-bit add wraps back to 0 there
    localparam logic [1:0] LAST_CNT = 2'(AES_NCOLS - NCOL);
    localparam logic [1:0] CNT_STEP = 2'(NCOL);

    aes_seq_e               state_q, state_d;
    logic [AES_STATE_W-1:0] work_q, work_wb, out_q;
    logic [1:0]             cnt_q;
    logic                   byp_q;
    logic                   rdy_en_q;
    logic [1:0]             col_idx  [NCOL];
    logic [AES_COL_W-1:0]   col_data [NCOL];
    logic [AES_COL_W-1:0]   col_res  [NCOL];

    genvar g;
    generate
        for (g = 0; g < NCOL; g++) begin : g_col
            assign col_idx[g]  = cnt_q + 2'(g);
            assign col_data[g] = work_q[AES_STATE_W-1-AES_COL_W*col_idx[g] -: AES_COL_W];
            aes_inv_mix_col u_imc (
                .col_in  (col_data[g]),
                .col_out (col_res[g])
            );
        end
    endgenerate

    // Work register with the current column group replaced by its transform
    always_comb begin
        work_wb = work_q;
        if (!byp_q) begin
            for (int i = 0; i < NCOL; i++) begin
                work_wb[AES_STATE_W-1-AES_COL_W*col_idx[i] -: AES_COL_W] = col_res[i];
            end
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            AES_SEQ_IDLE: if (in_valid && in_ready)         state_d = AES_SEQ_RUN;
            AES_SEQ_RUN:  if (byp_q || cnt_q == LAST_CNT)   state_d = AES_SEQ_DONE;
            AES_SEQ_DONE: if (out_ready)                    state_d = AES_SEQ_IDLE;
            default:                                        state_d = AES_SEQ_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= AES_SEQ_IDLE;
        else        state_q <= state_d;
    end

    // Capture, column write-back and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            out_q    <= '0;
            cnt_q    <= 2'd0;
            byp_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            unique case (state_q)
                AES_SEQ_IDLE: begin
                    if (in_valid && in_ready) begin
                        work_q <= in_state;
                        byp_q  <= in_bypass;
                        cnt_q  <= 2'd0;
                    end
                end
                AES_SEQ_RUN: begin
                    work_q <= work_wb;
                    cnt_q  <= cnt_q + CNT_STEP;
                    if (state_d == AES_SEQ_DONE) out_q <= work_wb;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rdy_en_q && (state_q == AES_SEQ_IDLE);
    assign out_valid = (state_q == AES_SEQ_DONE);
    assign out_state = out_q;
    assign busy      = (state_q != AES_SEQ_IDLE);

endmodule

// File: tb/tb_aes_inv_mix_col_seq.sv
// Scoreboard bench for aes_inv_mix_col_seq: directed latency/backpressure/reset
// cases plus randomized traffic, checked against a log/antilog GF(2^8) model.
module tb_aes_inv_mix_col_seq;

    localparam logic [127:0] V1  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] R1  = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] VB  = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_bypass, out_ready;
    logic [127:0] in_state;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;

    logic         in_valid2, in_valid4, in_ready2, in_ready4;
    logic         out_valid2, out_valid4, busy2, busy4;
    logic [127:0] out_state2, out_state4;
    logic         byp24, ord24;

    aes_inv_mix_col_seq #(.NCOL(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state), .busy(busy));

    aes_inv_mix_col_seq #(.NCOL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_state(V1), .in_bypass(byp24), .out_valid(out_valid2),
        .out_ready(ord24), .out_state(out_state2), .busy(busy2));

    aes_inv_mix_col_seq #(.NCOL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_state(V1), .in_bypass(byp24), .out_valid(out_valid4),
        .out_ready(ord24), .out_state(out_state4), .busy(busy4));

    int n_checks = 0;
    int n_fail   = 0;
    int n_sent   = 0;
    int n_xfer   = 0;
    logic [127:0] exp_q[$];
    logic         rnd_rdy = 1'b0;

    // ---------------- reference model (log/antilog tables, generator 3) -----
    logic [7:0] gexp [0:255];
    logic [7:0] glog [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(int'(glog[a]) + int'(glog[b])) % 255];
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [31:0]  col;
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[127-32*c -: 32];
            for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], a[k]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    initial begin
        logic [7:0] x;
        x = 8'h01;
        glog[0] = 8'h00;
        gexp[255] = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = 8'(i);
            x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ------------------------------------------------
    // A transfer completes at the edge following a negedge with out_valid&out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_extra: got %h expected no transfer", out_state);
            end else begin
                check("scoreboard", out_state, exp_q.pop_front());
            end
        end
    end

    // Random downstream backpressure during the random phase
    always @(posedge clk) begin
        #1;
        if (rnd_rdy) out_ready = ($urandom % 3) != 0;
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic send(input logic [127:0] d, input logic byp);
        int   n;
        logic acc;
        n = 0;
        in_valid  = 1'b1;
        in_state  = d;
        in_bypass = byp;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 2000);
        if (!acc) begin
            check("send_timeout", 128'(n), 128'(0));
        end else begin
            exp_q.push_back(byp ? d : ref_imc(d));
            n_sent++;
        end
        in_valid  = 1'b0;
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        int lat, l2, l4, n;
        logic [127:0] s2, s4;
        rst_n = 1'b0; in_valid = 1'b0; in_bypass = 1'b0; out_ready = 1'b0;
        in_state = '0; in_valid2 = 1'b0; in_valid4 = 1'b0; byp24 = 1'b0; ord24 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  128'(in_ready),  128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_state", out_state,       128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        @(negedge clk) rst_n = 1'b1;
        #1 check("rel_in_ready_before_edge", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        check("rel_in_ready_after_edge", 128'(in_ready), 128'(1));

        // Test 1: known vector, latency 4
        out_ready = 1'b1;
        send(V1, 1'b0);
        check("t1_busy", 128'(busy), 128'(1));
        check("t1_in_ready_run", 128'(in_ready), 128'(0));
        wait_valid(lat);
        check("t1_latency", 128'(lat), 128'(4));
        check("t1_value", out_state, R1);
        @(posedge clk); #1;

        // Test 2: bypass, latency 1, unmodified
        send(VB, 1'b1);
        wait_valid(lat);
        check("t2_latency", 128'(lat), 128'(1));
        check("t2_value", out_state, VB);
        @(posedge clk); #1;

        // Test 3: backpressure for 10 cycles with junk on the input side
        out_ready = 1'b0;
        send(V1, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check("t3_hold_valid", 128'(out_valid), 128'(1));
            check("t3_hold_state", out_state, R1);
            check("t3_in_ready",   128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_release_in_ready",  128'(in_ready),  128'(1));
        check("t3_release_out_valid", 128'(out_valid), 128'(0));

        // Test 4: reset after two columns, then a clean run
        send(V1, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_out_valid", 128'(out_valid), 128'(0));
        check("t4_out_state", out_state,       128'(0));
        check("t4_busy",      128'(busy),      128'(0));
        check("t4_in_ready",  128'(in_ready),  128'(0));
        void'(exp_q.pop_back());
        n_sent--;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(V1, 1'b0);
        wait_valid(lat);
        check("t4_latency", 128'(lat), 128'(4));
        check("t4_value", out_state, R1);
        @(posedge clk); #1;

        // Test 5: NCOL=2 and NCOL=4 latency and value
        check("t5_ready2", 128'(in_ready2), 128'(1));
        check("t5_ready4", 128'(in_ready4), 128'(1));
        in_valid2 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0; in_valid4 = 1'b0;
        l2 = 0; l4 = 0; s2 = '0; s4 = '0;
        for (int i = 1; i <= 10; i++) begin
            if (out_valid2 && l2 == 0) begin l2 = i - 1; s2 = out_state2; end
            if (out_valid4 && l4 == 0) begin l4 = i - 1; s4 = out_state4; end
            @(posedge clk); #1;
        end
        check("t5_latency2", 128'(l2), 128'(2));
        check("t5_latency4", 128'(l4), 128'(1));
        check("t5_value2", s2, R1);
        check("t5_value4", s4, R1);

        // Test 6: random traffic with random gaps and backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom % 3) @(posedge clk);
            #1;
            send({$urandom, $urandom, $urandom, $urandom}, ($urandom % 8) == 0);
        end
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("t6_queue_drained", 128'(exp_q.size()), 128'(0));
        check("t6_transfer_count", 128'(n_xfer), 128'(n_sent));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
